// File: rtl/interrupt_arbiter.sv
// Interrupt entry sequencer: fixed-priority winner selection, boundary-gated trap request,
// and a post-ack holdoff window that masks stale request lines.
module interrupt_arbiter #(
  parameter int unsigned HOLDOFF_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        irq1,
  input  logic        irq3,
  input  logic        irq5,
  input  logic        irq7,
  input  logic        irq9,
  input  logic        irq11,
  input  logic [31:0] mideleg,
  input  logic        instr_boundary,
  input  logic        trap_ack,
  input  logic        sync_trap,
  output logic        trap_req,
  output logic [3:0]  trap_cause,
  output logic        trap_to_s,
  output logic [1:0]  arb_state,
  output logic [15:0] taken_count
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StReq  = 2'd2,
    StHold = 2'd3
  } state_e;

  localparam logic [3:0] HoldLoad  = 4'(HOLDOFF_CYCLES);
  // An abort must still spend one cycle in HOLD even with a zero holdoff.
  localparam logic [3:0] AbortLoad = (HOLDOFF_CYCLES == 0) ? 4'd1 : HoldLoad;

  state_e      state_q, state_d;
  logic        trap_req_q, trap_req_d;
  logic [3:0]  trap_cause_q, trap_cause_d;
  logic        trap_to_s_q, trap_to_s_d;
  logic [15:0] taken_count_q, taken_count_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;

  logic [3:0]  win_code;
  logic        any_irq;

  assign any_irq = irq1 | irq3 | irq5 | irq7 | irq9 | irq11;

  always_comb begin
    win_code = 4'd0;
    if (irq11)      win_code = 4'd11;
    else if (irq3)  win_code = 4'd3;
    else if (irq7)  win_code = 4'd7;
    else if (irq9)  win_code = 4'd9;
    else if (irq1)  win_code = 4'd1;
    else if (irq5)  win_code = 4'd5;
  end

  always_comb begin
    state_d       = state_q;
    trap_req_d    = trap_req_q;
    trap_cause_d  = trap_cause_q;
    trap_to_s_d   = trap_to_s_q;
    taken_count_d = taken_count_q;
    hold_cnt_d    = hold_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (any_irq) begin
          trap_cause_d = win_code;
          trap_to_s_d  = mideleg[win_code];
          state_d      = StArm;
        end
      end
      StArm: begin
        if (!any_irq) begin
          state_d = StIdle;
        end else begin
          trap_cause_d = win_code;
          trap_to_s_d  = mideleg[win_code];
          if (sync_trap) begin
            state_d    = StHold;
            hold_cnt_d = AbortLoad;
          end else if (instr_boundary) begin
            trap_req_d = 1'b1;
            state_d    = StReq;
          end
        end
      end
      StReq: begin
        if (trap_ack) begin
          trap_req_d    = 1'b0;
          taken_count_d = taken_count_q + 16'd1;
          if (HoldLoad == 4'd0) begin
            state_d = StIdle;
          end else begin
            state_d    = StHold;
            hold_cnt_d = HoldLoad;
          end
        end else if (sync_trap) begin
          trap_req_d = 1'b0;
          state_d    = StHold;
          hold_cnt_d = AbortLoad;
        end
      end
      StHold: begin
        if (hold_cnt_q <= 4'd1) begin
          hold_cnt_d = 4'd0;
          state_d    = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      trap_req_q    <= 1'b0;
      trap_cause_q  <= 4'd0;
      trap_to_s_q   <= 1'b0;
      taken_count_q <= 16'd0;
      hold_cnt_q    <= 4'd0;
    end else begin
      state_q       <= state_d;
      trap_req_q    <= trap_req_d;
      trap_cause_q  <= trap_cause_d;
      trap_to_s_q   <= trap_to_s_d;
      taken_count_q <= taken_count_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign trap_req    = trap_req_q;
  assign trap_cause  = trap_cause_q;
  assign trap_to_s   = trap_to_s_q;
  assign arb_state   = state_q;
  assign taken_count = taken_count_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter: default holdoff instance plus a zero-holdoff instance.
module tb_interrupt_arbiter;

  logic        clk;
  logic        resetn;
  logic        irq1, irq3, irq5, irq7, irq9, irq11;
  logic [31:0] mideleg;
  logic        instr_boundary, trap_ack, sync_trap;

  logic        trap_req, trap_to_s;
  logic [3:0]  trap_cause;
  logic [1:0]  arb_state;
  logic [15:0] taken_count;

  logic        z_trap_req, z_trap_to_s;
  logic [3:0]  z_trap_cause;
  logic [1:0]  z_arb_state;
  logic [15:0] z_taken_count;

  int n_checks = 0;
  int n_errors = 0;

  interrupt_arbiter #(.HOLDOFF_CYCLES(2)) u_dut (
    .clk(clk), .resetn(resetn),
    .irq1(irq1), .irq3(irq3), .irq5(irq5), .irq7(irq7), .irq9(irq9), .irq11(irq11),
    .mideleg(mideleg), .instr_boundary(instr_boundary), .trap_ack(trap_ack),
    .sync_trap(sync_trap), .trap_req(trap_req), .trap_cause(trap_cause),
    .trap_to_s(trap_to_s), .arb_state(arb_state), .taken_count(taken_count)
  );

  interrupt_arbiter #(.HOLDOFF_CYCLES(0)) u_dut0 (
    .clk(clk), .resetn(resetn),
    .irq1(irq1), .irq3(irq3), .irq5(irq5), .irq7(irq7), .irq9(irq9), .irq11(irq11),
    .mideleg(mideleg), .instr_boundary(instr_boundary), .trap_ack(trap_ack),
    .sync_trap(sync_trap), .trap_req(z_trap_req), .trap_cause(z_trap_cause),
    .trap_to_s(z_trap_to_s), .arb_state(z_arb_state), .taken_count(z_taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    irq1 = 0; irq3 = 0; irq5 = 0; irq7 = 0; irq9 = 0; irq11 = 0;
    mideleg = 32'd0; instr_boundary = 0; trap_ack = 0; sync_trap = 0;
  endtask

  initial begin
    clear_inputs();
    resetn = 0;

    // Reset held for three cycles
    repeat (3) step();
    check("rst_req", {31'd0, trap_req}, 0);
    check("rst_cause", {28'd0, trap_cause}, 0);
    check("rst_to_s", {31'd0, trap_to_s}, 0);
    check("rst_state", {30'd0, arb_state}, 0);
    check("rst_count", {16'd0, taken_count}, 0);
    resetn = 1;

    // MTI, M-mode, boundary open from the start
    irq7 = 1; instr_boundary = 1;
    step();
    check("mti_arm", {30'd0, arb_state}, 1);
    step();
    check("mti_req", {31'd0, trap_req}, 1);
    check("mti_cause", {28'd0, trap_cause}, 7);
    check("mti_to_s", {31'd0, trap_to_s}, 0);
    step(); step();
    check("mti_req_held", {31'd0, trap_req}, 1);
    trap_ack = 1;
    step();
    check("mti_ack_req", {31'd0, trap_req}, 0);
    check("mti_ack_count", {16'd0, taken_count}, 1);
    check("mti_hold1", {30'd0, arb_state}, 3);
    clear_inputs();
    step();
    check("mti_hold2", {30'd0, arb_state}, 3);
    step();
    check("mti_idle", {30'd0, arb_state}, 0);

    // STI delegated, preempted by MEI while armed
    irq5 = 1; mideleg = 32'h20;
    step();
    check("sti_arm", {30'd0, arb_state}, 1);
    check("sti_cause", {28'd0, trap_cause}, 5);
    check("sti_to_s", {31'd0, trap_to_s}, 1);
    step();
    step();
    irq11 = 1;
    step();
    check("mei_preempt_cause", {28'd0, trap_cause}, 11);
    check("mei_preempt_to_s", {31'd0, trap_to_s}, 0);
    check("mei_still_arm", {30'd0, arb_state}, 1);
    instr_boundary = 1;
    step();
    check("mei_req", {31'd0, trap_req}, 1);
    check("mei_req_cause", {28'd0, trap_cause}, 11);
    clear_inputs();
    trap_ack = 1;
    step();
    check("mei_ack_count", {16'd0, taken_count}, 2);
    trap_ack = 0;
    step(); step();
    check("mei_idle", {30'd0, arb_state}, 0);

    // SEI delegated: REQ outputs frozen against line changes
    irq9 = 1; mideleg = 32'h200; instr_boundary = 1;
    step(); step();
    check("sei_req", {31'd0, trap_req}, 1);
    irq9 = 0; irq3 = 1;
    step();
    check("sei_frozen_req", {31'd0, trap_req}, 1);
    check("sei_frozen_cause", {28'd0, trap_cause}, 9);
    check("sei_frozen_to_s", {31'd0, trap_to_s}, 1);
    check("sei_frozen_state", {30'd0, arb_state}, 2);
    step();
    check("sei_frozen_cause2", {28'd0, trap_cause}, 9);
    clear_inputs();
    trap_ack = 1;
    step();
    check("sei_ack_count", {16'd0, taken_count}, 3);
    trap_ack = 0;
    step(); step();

    // Synchronous abort from REQ leaves the counter alone
    irq1 = 1; instr_boundary = 1;
    step(); step();
    check("ssi_req", {31'd0, trap_req}, 1);
    check("ssi_cause", {28'd0, trap_cause}, 1);
    sync_trap = 1;
    step();
    check("abort_req", {31'd0, trap_req}, 0);
    check("abort_state", {30'd0, arb_state}, 3);
    check("abort_count", {16'd0, taken_count}, 3);
    clear_inputs();
    step(); step();
    check("abort_idle", {30'd0, arb_state}, 0);

    // Ack and sync together: ack wins
    irq1 = 1; instr_boundary = 1;
    step(); step();
    trap_ack = 1; sync_trap = 1;
    step();
    check("both_req", {31'd0, trap_req}, 0);
    check("both_state", {30'd0, arb_state}, 3);
    check("both_count", {16'd0, taken_count}, 4);
    clear_inputs();
    step(); step();

    // Ack outside REQ is ignored
    trap_ack = 1;
    step();
    check("stray_ack_count", {16'd0, taken_count}, 4);
    trap_ack = 0;

    // Asynchronous reset while requesting
    irq3 = 1; instr_boundary = 1;
    step(); step();
    check("msi_req", {31'd0, trap_req}, 1);
    #1 resetn = 0;
    #1;
    check("async_rst_req", {31'd0, trap_req}, 0);
    check("async_rst_state", {30'd0, arb_state}, 0);
    check("async_rst_count", {16'd0, taken_count}, 0);
    clear_inputs();
    step();
    resetn = 1;

    // Counter wrap
    force u_dut.taken_count_q = 16'hFFFF;
    step();
    release u_dut.taken_count_q;
    check("preload_count", {16'd0, taken_count}, 32'hFFFF);
    irq7 = 1; instr_boundary = 1;
    step(); step();
    trap_ack = 1;
    step();
    check("wrap_count", {16'd0, taken_count}, 0);
    clear_inputs();
    step(); step();

    // Zero holdoff instance
    resetn = 0;
    step();
    resetn = 1;
    irq7 = 1; instr_boundary = 1;
    step();
    check("z_arm", {30'd0, z_arb_state}, 1);
    step();
    check("z_req", {31'd0, z_trap_req}, 1);
    trap_ack = 1;
    step();
    check("z_ack_state", {30'd0, z_arb_state}, 0);
    check("z_ack_req", {31'd0, z_trap_req}, 0);
    check("z_ack_count", {16'd0, z_taken_count}, 1);
    trap_ack = 0;
    step();
    check("z_rearm", {30'd0, z_arb_state}, 1);
    step();
    check("z_rereq", {31'd0, z_trap_req}, 1);
    sync_trap = 1;
    step();
    check("z_abort_state", {30'd0, z_arb_state}, 3);
    check("z_abort_req", {31'd0, z_trap_req}, 0);
    sync_trap = 0;
    step();
    check("z_abort_idle", {30'd0, z_arb_state}, 0);
    step();
    check("z_abort_rearm", {30'd0, z_arb_state}, 1);
    check("z_abort_count", {16'd0, z_taken_count}, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
